// File: rtl/sys1_pkg.sv
// Shared constants and types for the SEGASYSTEM1 input conditioner.
package sys1_pkg;

    // hps_io joystick bit map
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_BTN1   = 4;
    localparam int JOY_BTN2   = 5;
    localparam int JOY_BTN3   = 6;
    localparam int JOY_BTN4   = 7;
    localparam int JOY_BTN5   = 8;
    localparam int JOY_START1 = 9;
    localparam int JOY_START2 = 10;
    localparam int JOY_COIN   = 11;
    localparam int JOY_PAUSE  = 12;

    localparam int SYSMODE_WATER = 3;
    localparam int SYSMODE_SPIN  = 5;

    typedef enum logic [1:0] {CS_IDLE, CS_PULSE, CS_GAP, CS_WAIT_REL} coin_state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sys1_input_conditioner_coin_shaper.sv
// Coin pulse shaper: one fixed-length pulse per press, then a lockout and a
// wait for release so a held or bouncing coin switch never double-counts.
module sys1_input_conditioner_coin_shaper
    import sys1_pkg::*;
#(
    parameter int unsigned PULSE = 2_400_000,
    parameter int unsigned GAP   = 4_800_000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_i,
    output logic coin_o,
    output logic busy_o
);

    localparam int unsigned CNT_W = $clog2(max2(PULSE, GAP) + 1);

    coin_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_q;
    logic             coin_q;
    logic             busy_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CS_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            coin_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            prev_q <= coin_i;
            case (state_q)
                CS_IDLE: begin
                    if (coin_i && !prev_q) begin
                        state_q <= CS_PULSE;
                        cnt_q   <= CNT_W'(PULSE - 1);
                        coin_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                CS_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= CS_GAP;
                        cnt_q   <= CNT_W'(GAP - 1);
                        coin_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CS_GAP: begin
                    if (cnt_q == '0) state_q <= CS_WAIT_REL;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                CS_WAIT_REL: begin
                    if (!coin_i) begin
                        state_q <= CS_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= CS_IDLE;
            endcase
        end
    end

    assign coin_o = coin_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/sys1_input_conditioner.sv
// Conditions raw hps_io controls into the active-low INP0/1/2 bytes plus the
// pause and dim-video controls for the SEGASYSTEM1 core.
module sys1_input_conditioner
    import sys1_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned COIN_PULSE_CYC = 2_400_000,
    parameter int unsigned COIN_GAP_CYC   = 4_800_000,
    parameter int unsigned DIM_CYC        = 480_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    input  logic [7:0]  spin,
    input  logic [2:0]  mouse_btn,
    input  logic [7:0]  sysmode,
    input  logic        osd_status,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    output logic [7:0]  inp0,
    output logic [7:0]  inp1,
    output logic [7:0]  inp2,
    output logic        pause,
    output logic        dim_video,
    output logic        coin_busy
);

    localparam int unsigned SYNC_W = 1 + 3 + 13 + 13;
    localparam int unsigned DIM_W  = $clog2(DIM_CYC + 1);

    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic              osd_s;
    logic [2:0]        mouse_s;
    logic [12:0]       joy1_s, joy2_s, joy;
    logic              unused_bits;

    // Bits 15:13 carry nothing this core consumes, so they are not synchronised.
    assign unused_bits = ^{joy1[15:13], joy2[15:13]};

    // NOTE: the synchroniser chain is reset so the first post-reset samples
    // are a known all-released state rather than X.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {osd_status, mouse_btn, joy2[12:0], joy1[12:0]};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {osd_s, mouse_s, joy2_s, joy1_s} = sync_q[SYNC_STAGES-1];
    assign joy = joy1_s | joy2_s;

    logic coin;
    sys1_input_conditioner_coin_shaper #(
        .PULSE (COIN_PULSE_CYC),
        .GAP   (COIN_GAP_CYC)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .coin_i  (joy[JOY_COIN]),
        .coin_o  (coin),
        .busy_o  (coin_busy)
    );

    logic [7:0] inp01_d, inp2_d;
    logic [3:0] water_r;
    logic       spin_t;

    // NOTE: every output of this block is assigned a default first, so no
    // mode path can leave a value held and infer a latch.
    always_comb begin
        water_r = joy1_s[7:4] | joy2_s[3:0];
        spin_t  = joy[JOY_BTN1] | (mouse_s != 3'b000);
        inp01_d = ~{joy[JOY_LEFT], joy[JOY_RIGHT], joy[JOY_UP], joy[JOY_DOWN],
                    1'b0, joy[JOY_BTN2], joy[JOY_BTN1], joy[JOY_BTN3]};
        inp2_d  = ~{2'b00, joy[JOY_START2], joy[JOY_START1], 3'b000, coin};
        if (sysmode[SYSMODE_SPIN]) begin
            inp01_d = ~spin;
            inp2_d  = ~{spin_t, spin_t, joy[JOY_START2], joy[JOY_START1], 3'b000, coin};
        end else if (sysmode[SYSMODE_WATER]) begin
            inp01_d = ~{joy1_s[1], joy1_s[0], joy1_s[3], joy1_s[2],
                        water_r[1], water_r[0], water_r[3], water_r[2]};
            inp2_d  = ~{joy1_s[JOY_BTN5], joy1_s[JOY_BTN5], joy[JOY_START2],
                        joy[JOY_START1], 3'b000, coin};
        end
    end

    logic [7:0]       inp0_q, inp1_q, inp2_q;
    logic             pause_prev_q, pause_toggle_q, pause_q, dim_q;
    logic [DIM_W-1:0] dim_cnt_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            inp0_q         <= 8'hFF;
            inp1_q         <= 8'hFF;
            inp2_q         <= 8'hFF;
            pause_prev_q   <= 1'b0;
            pause_toggle_q <= 1'b0;
            pause_q        <= 1'b0;
            dim_cnt_q      <= '0;
            dim_q          <= 1'b0;
        end else begin
            inp0_q       <= inp01_d;
            inp1_q       <= inp01_d;
            inp2_q       <= inp2_d;
            pause_prev_q <= joy[JOY_PAUSE];
            if (joy[JOY_PAUSE] && !pause_prev_q) pause_toggle_q <= ~pause_toggle_q;
            pause_q <= hs_access | pause_toggle_q | (osd_s & osd_pause_en);
            if (!pause_toggle_q)                     dim_cnt_q <= '0;
            else if (dim_cnt_q != DIM_W'(DIM_CYC))   dim_cnt_q <= dim_cnt_q + 1'b1;
            // Gated by the toggle so dim falls on the same cycle as pause.
            dim_q <= pause_toggle_q && (dim_cnt_q == DIM_W'(DIM_CYC));
        end
    end

    assign inp0      = inp0_q;
    assign inp1      = inp1_q;
    assign inp2      = inp2_q;
    assign pause     = pause_q;
    assign dim_video = dim_q;

endmodule

// File: tb/tb_sys1_input_conditioner.sv
// Self-checking bench: cycle model of the conditioner plus directed literal checks.
module tb_sys1_input_conditioner;

    localparam int S = 2;
    localparam int P = 4;
    localparam int G = 6;
    localparam int D = 10;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] joy1 = '0, joy2 = '0;
    logic [7:0]  spin = '0, sysmode = '0;
    logic [2:0]  mouse_btn = '0;
    logic        osd_status = 1'b0, osd_pause_en = 1'b0, hs_access = 1'b0;
    logic [7:0]  inp0, inp1, inp2;
    logic        pause, dim_video, coin_busy;

    sys1_input_conditioner #(
        .SYNC_STAGES(S), .COIN_PULSE_CYC(P), .COIN_GAP_CYC(G), .DIM_CYC(D)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy1(joy1), .joy2(joy2),
        .spin(spin), .mouse_btn(mouse_btn), .sysmode(sysmode),
        .osd_status(osd_status), .osd_pause_en(osd_pause_en), .hs_access(hs_access),
        .inp0(inp0), .inp1(inp1), .inp2(inp2), .pause(pause),
        .dim_video(dim_video), .coin_busy(coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: inputs delayed by the synchroniser depth, coin as a timestamped
    // pulse/lockout window, dim as a run length of paused cycles.
    typedef struct packed {
        logic       osd;
        logic [2:0] mouse;
        logic [15:0] j2;
        logic [15:0] j1;
    } raw_t;

    raw_t       line [S];
    logic [7:0] m_inp0, m_inp1, m_inp2;
    logic       m_pause, m_dim, m_busy, m_coin, m_toggle, m_prev11, m_prev12, m_active;
    int         m_t0, m_k, m_run;

    always @(posedge clk_sys or negedge reset_n) begin : model
        raw_t       s;
        logic [15:0] j;
        logic [7:0] o0, o2;
        logic [3:0] r;
        logic       coin_old, tog_old, t;
        if (!reset_n) begin
            for (int i = 0; i < S; i++) line[i] = '0;
            m_inp0 = 8'hFF; m_inp1 = 8'hFF; m_inp2 = 8'hFF;
            m_pause = 0; m_dim = 0; m_busy = 0; m_coin = 0; m_toggle = 0;
            m_prev11 = 0; m_prev12 = 0; m_active = 0; m_t0 = 0; m_k = 0; m_run = 0;
        end else begin
            s = line[S-1];
            for (int i = S - 1; i > 0; i--) line[i] = line[i-1];
            line[0] = {osd_status, mouse_btn, joy2, joy1};
            j = s.j1 | s.j2;
            coin_old = m_coin;
            tog_old  = m_toggle;
            m_k++;
            if (!m_active) begin
                if (j[11] && !m_prev11) begin
                    m_active = 1;
                    m_t0 = m_k;
                end
            end else if ((m_k - m_t0 > P + G) && !j[11]) begin
                m_active = 0;
            end
            m_coin   = m_active && (m_k - m_t0 < P);
            m_busy   = m_active;
            m_prev11 = j[11];
            if (sysmode[5]) begin
                t  = j[4] | (s.mouse != 3'b000);
                o0 = ~spin;
                o2 = ~{t, t, j[10], j[9], 3'b000, coin_old};
            end else if (sysmode[3]) begin
                r  = s.j1[7:4] | s.j2[3:0];
                o0 = ~{s.j1[1], s.j1[0], s.j1[3], s.j1[2], r[1], r[0], r[3], r[2]};
                o2 = ~{s.j1[8], s.j1[8], j[10], j[9], 3'b000, coin_old};
            end else begin
                o0 = ~{j[1], j[0], j[3], j[2], 1'b0, j[5], j[4], j[6]};
                o2 = ~{2'b00, j[10], j[9], 3'b000, coin_old};
            end
            m_inp0 = o0; m_inp1 = o0; m_inp2 = o2;
            if (j[12] && !m_prev12) m_toggle = !m_toggle;
            m_prev12 = j[12];
            m_pause  = hs_access | tog_old | (s.osd & osd_pause_en);
            m_dim    = tog_old && (m_run >= D);
            m_run    = tog_old ? m_run + 1 : 0;
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n) begin
            check("model_inp0", inp0, m_inp0);
            check("model_inp1", inp1, m_inp1);
            check("model_inp2", inp2, m_inp2);
            check("model_pause", pause, m_pause);
            check("model_dim", dim_video, m_dim);
            check("model_busy", coin_busy, m_busy);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int first;

        // Reset with everything pressed
        joy1 = 16'hFFFF;
        tick(3);
        check("rst_inp0", inp0, 8'hFF);
        check("rst_inp1", inp1, 8'hFF);
        check("rst_inp2", inp2, 8'hFF);
        check("rst_pause", pause, 1'b0);
        check("rst_dim", dim_video, 1'b0);
        check("rst_busy", coin_busy, 1'b0);
        reset_n = 1'b1;
        tick(2);
        check("lat_inp0_early", inp0, 8'hFF);
        tick(1);
        check("lat_inp0_3cyc", inp0, 8'h08);
        joy1 = '0;
        tick(30);
        check("startup_pause", pause, 1'b1);
        check("startup_dim", dim_video, 1'b1);
        joy1[12] = 1'b1; tick(1); joy1[12] = 1'b0;
        tick(5);
        check("startup_unpause", pause, 1'b0);

        // Held coin: single 4-cycle pulse starting 4 cycles after the press
        joy1[11] = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            tick(1);
            check("coin_hold", inp2[0], (n >= 4 && n <= 7) ? 1'b0 : 1'b1);
        end
        check("coin_hold_busy", coin_busy, 1'b1);
        joy1[11] = 1'b0;
        tick(5);
        check("coin_release_idle", coin_busy, 1'b0);
        joy1[11] = 1'b1;
        lows = 0;
        for (int n = 1; n <= 15; n++) begin
            tick(1);
            if (!inp2[0]) lows++;
        end
        check("coin_second_pulse", lows, 4);
        joy1[11] = 1'b0;
        tick(20);

        // Re-press during the lockout gap is ignored
        joy1[11] = 1'b1; tick(5);
        joy1[11] = 1'b0; tick(3);
        joy1[11] = 1'b1;
        lows = 0;
        for (int n = 9; n <= 30; n++) begin
            tick(1);
            if (!inp2[0]) lows++;
        end
        check("coin_gap_ignored", lows, 0);
        check("coin_gap_busy", coin_busy, 1'b1);
        joy1[11] = 1'b0;
        tick(5);
        check("coin_gap_release", coin_busy, 1'b0);
        tick(10);

        // Spinner and water-match mappings
        sysmode = 8'h20; spin = 8'h5A; mouse_btn = 3'b001;
        tick(4);
        check("spin_inp0", inp0, 8'hA5);
        check("spin_inp1", inp1, 8'hA5);
        check("spin_inp2", inp2, 8'h3F);
        sysmode = 8'h08; mouse_btn = 3'b000; joy1[8] = 1'b1;
        tick(4);
        check("water_inp2", inp2, 8'h3F);
        check("water_inp0", inp0, 8'hFF);
        sysmode = 8'h00; spin = 8'h00; joy1 = '0;
        tick(4);

        // User pause and dim timing
        joy1[12] = 1'b1; tick(1); joy1[12] = 1'b0;
        tick(4);
        check("pause_on", pause, 1'b1);
        check("dim_not_yet", dim_video, 1'b0);
        first = -1;
        for (int n = 6; n <= 20; n++) begin
            tick(1);
            if (dim_video && first < 0) first = n;
        end
        check("dim_delay", first, 14);
        joy1[12] = 1'b1; tick(1); joy1[12] = 1'b0;
        tick(2);
        check("pause_still_on", pause, 1'b1);
        check("dim_still_on", dim_video, 1'b1);
        tick(1);
        check("pause_off", pause, 1'b0);
        check("dim_off", dim_video, 1'b0);

        // OSD and hiscore pause never dim
        osd_status = 1'b1; osd_pause_en = 1'b1;
        tick(20);
        check("osd_pause", pause, 1'b1);
        check("osd_no_dim", dim_video, 1'b0);
        osd_status = 1'b0; osd_pause_en = 1'b0;
        tick(4);
        check("osd_release", pause, 1'b0);
        hs_access = 1'b1;
        tick(2);
        check("hs_pause", pause, 1'b1);
        hs_access = 1'b0;
        tick(3);
        check("hs_release", pause, 1'b0);

        // Reset in the middle of a coin pulse
        joy1[11] = 1'b1;
        tick(5);
        check("coin_before_reset", inp2[0], 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("reset_abort_inp2", inp2, 8'hFF);
        check("reset_abort_busy", coin_busy, 1'b0);
        tick(2);
        joy1 = '0;
        reset_n = 1'b1;
        tick(10);
        check("post_reset_inp2", inp2, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
